alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised successor to the 16-bit single-cycle ALU. Same 5-bit op encoding: opcode = aluop[4:1], signed/mode = aluop[0]. Adds generic width, a valid/ready handshake, iterative MUL/DIV (codes 6 and 7), arithmetic shift right, and carry/overflow/div-by-zero status. It sits between register-file read and writeback; the decoder stalls on O_ready low.

Parameters:
W, 16, datapath width (power of 2, >=8)
IMMW, 8, immediate width (IMMW <= W)
SW, $clog2(W), shift-amount / bit-index width (derived, not overridable)

Ports:
I_clk  in  1  clock, rising edge
I_rst  in  1  synchronous reset, active-high
I_valid  in  1  operation request
O_ready  out  1  high when IDLE; request accepted when I_valid && O_ready
I_aluop  in  5  [4:1] opcode, [0] signed/mode
I_dataA  in  W  operand A
I_dataB  in  W  operand B
I_imm  in  IMMW  immediate
O_valid  out  1  one-cycle pulse: result outputs are new
O_dataResult  out  W  result / MUL low half / DIV quotient
O_dataHigh  out  W  MUL high half / DIV remainder; 0 for other ops
O_shldBranch  out  1  branch decision
O_status  out  3  {divByZero, overflow, carry}

Behaviour:
- Interface: one clock I_clk; reset I_rst is synchronous and active-high.
- Reset: state IDLE. O_valid, O_dataResult, O_dataHigh, O_shldBranch and O_status all 0. O_ready=1 on the first cycle after reset deasserts.
- FSM states: IDLE, MUL, DIV. O_ready = (state==IDLE), combinational.
- Single-cycle ops (accept in IDLE): outputs registered at the accepting edge. O_valid=1 the next cycle, for one cycle. Latency 1.
- ADD (0) / SUB (1): W-bit wrap result.
  - carry = unsigned carry-out for ADD, borrow for SUB.
  - overflow = signed overflow, only when aluop[0]=1, else 0.
- OR (2), AND (3), XOR (4), NOT (5, ~A).
- Load (8): aluop[0]=1 puts imm in bits [W-1:W-IMMW], zeros elsewhere; else imm zero-extended.
- Cmp (9): result zero-extended flags [0] A==B, [1] A==0, [2] B==0, [3] A>B, [4] A<B. Signed comparison if aluop[0]=1.
- SHL (10): A << B[SW-1:0].
- SHR (11): aluop[0]=0 logical; aluop[0]=1 arithmetic (sign-fill). Shift amount B[SW-1:0].
- JMPA (12): result = aluop[0] ? A : zero-extended imm. Branch = 1.
- JMPR (13): result = A. Branch = B[{aluop[0], imm[SW-2:0]}].
- Codes 14 and 15: result 0, branch 0, status 0, O_valid still pulses.
- O_shldBranch = 0 for every non-jump op. O_status = 0 for ops other than ADD, SUB and DIV-by-zero.
- MUL (6): IDLE->MUL. W iterations of shift-add on operand magnitudes (signed if aluop[0]=1), one per cycle. Final sign fix in the last cycle, then back to IDLE.
  - 2W-bit product split {O_dataHigh, O_dataResult}.
  - O_valid asserts W+1 cycles after accept.
- DIV (7): IDLE->DIV, restoring division on magnitudes, W cycles. Latency W+1.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1 gives quotient MIN, remainder 0 (no trap).
- DIV with B==0: no iteration, latency 1. Quotient = all ones, remainder = A, divByZero=1.
- I_valid while busy: ignored, no queueing. Operands are captured at accept; later input changes have no effect.
- Outputs hold their last value between O_valid pulses.
- I_rst during MUL/DIV: aborts, state IDLE, no O_valid for the aborted op.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ADD..JMPR, MUL=6, DIV=7)
  - Cmp flag bit indices
  - O_status bit indices
  - FSM state encoding
- Sub-module alu_muldiv_iter: the iterative MUL/DIV datapath. Ports are start, signed, op, A, B, busy, done, hi, lo. The top FSM sequences it.

Test Plan:
- ADD unsigned: aluop=5'b00000, A=0xFFFF, B=0x0001 -> next cycle O_valid=1, result 0x0000, status=3'b001. SUB signed (5'b00011) with A=0x8000, B=0x0001 -> result 0x7FFF, overflow=1.
- MUL signed: aluop=5'b01101, A=0xFFFD (-3), B=0x0007 -> O_ready low 16 cycles, O_valid on cycle 17, result 0xFFEB, high 0xFFFF. Back-to-back I_valid during busy is ignored.
- DIV: unsigned aluop=5'b01110, 100/7 -> quotient 0x000E, remainder 0x0002. Signed 5'b01111, 0xFFF9/0x0002 -> quotient 0xFFFD, remainder 0xFFFF.
- DIV by zero: A=0x1234, B=0 -> latency 1, result 0xFFFF, high 0x1234, status=3'b100.
- Cmp: A=0x8000, B=0x0001. Signed -> result 0x0010. Unsigned -> 0x0008. SHR arithmetic (5'b10111) on 0x8000 by 4 -> 0xF800.
- JMPR: aluop=5'b11011, B=0x0400, imm[2:0]=2 -> index 10, branch=1.
- Reset: assert I_rst at cycle 5 of a MUL -> no O_valid, all outputs 0, O_ready=1 the cycle after I_rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, compare-flag and status
// bit positions, and the sequencing FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_JMPA = 4'd12;
  localparam logic [3:0] OP_JMPR = 4'd13;

  localparam int CMP_EQ = 0;
  localparam int CMP_AZ = 1;
  localparam int CMP_BZ = 2;
  localparam int CMP_GT = 3;
  localparam int CMP_LT = 4;

  localparam int ST_CARRY = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_DBZ   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes; done_o flags the last iteration with the sign-fixed result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST = SW'(W - 1);

  logic          busy_q, busy_d;
  logic          div_q, div_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opb_q, opb_d;

  logic [W-1:0]   a_mag, b_mag, hi_n, lo_n;
  logic [W:0]     add, rem_sh, trial;
  logic [2*W-1:0] prod;

  assign a_mag = (signed_i && a_i[W-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[W-1]) ? -b_i : b_i;

  // One iteration: hi:lo is the running product (MUL) or remainder:dividend
  // with quotient bits shifted in from the right (DIV).
  assign add    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh = {hi_q, lo_q[W-1]};
  assign trial  = rem_sh - {1'b0, opb_q};

  always_comb begin
    if (div_q) begin
      hi_n = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
      lo_n = {lo_q[W-2:0], ~trial[W]};
    end else begin
      hi_n = add[W:1];
      lo_n = {add[0], lo_q[W-1:1]};
    end
  end

  assign prod = {hi_n, lo_n};

  always_comb begin
    if (div_q) begin
      lo_o = neg_q  ? -lo_n : lo_n;
      hi_o = rneg_q ? -hi_n : hi_n;
    end else begin
      {hi_o, lo_o} = neg_q ? -prod : prod;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);

  // NOTE: every next-state variable gets its hold value first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opb_d  = opb_q;
    if (busy_q) begin
      hi_d  = hi_n;
      lo_d  = lo_n;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = (op_i == OP_DIV);
      neg_d  = signed_i && (a_i[W-1] ^ b_i[W-1]);
      rneg_d = signed_i && a_i[W-1];
      hi_d   = '0;
      lo_d   = a_mag;
      opb_d  = b_mag;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Parametrised ALU with valid/ready handshake: single-cycle ops complete in one
// clock, MUL/DIV are sequenced through the iterative datapath.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int IMMW = 8
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [4:0]      I_aluop,
  input  logic [W-1:0]    I_dataA,
  input  logic [W-1:0]    I_dataB,
  input  logic [IMMW-1:0] I_imm,
  output logic            O_valid,
  output logic [W-1:0]    O_dataResult,
  output logic [W-1:0]    O_dataHigh,
  output logic            O_shldBranch,
  output logic [2:0]      O_status
);

  localparam int SW = $clog2(W);

  state_e state_q, state_d;

  logic         valid_q, valid_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] high_q, high_d;
  logic         br_q, br_d;
  logic [2:0]   st_q, st_d;

  logic [3:0]          op;
  logic                mode, accept, iter_start, iter_busy, iter_done;
  logic [W-1:0]        iter_hi, iter_lo, res_c, high_c;
  logic                br_c;
  logic [2:0]          st_c;
  logic [W:0]          sum, diff;
  logic [SW-1:0]       sh;
  logic signed [W-1:0] sra;

  assign op         = I_aluop[4:1];
  assign mode       = I_aluop[0];
  assign O_ready    = (state_q == S_IDLE);
  assign accept     = I_valid && O_ready;
  // Divide-by-zero is resolved in one cycle and never starts the iterator.
  assign iter_start = accept && ((op == OP_MUL) || (op == OP_DIV && I_dataB != '0));

  assign sum  = {1'b0, I_dataA} + {1'b0, I_dataB};
  assign diff = {1'b0, I_dataA} - {1'b0, I_dataB};
  assign sh   = I_dataB[SW-1:0];
  assign sra  = $signed(I_dataA) >>> sh;

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk_i    (I_clk),
    .rst_i    (I_rst),
    .start_i  (iter_start),
    .signed_i (mode),
    .op_i     (op),
    .a_i      (I_dataA),
    .b_i      (I_dataB),
    .busy_o   (iter_busy),
    .done_o   (iter_done),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo)
  );

  always_comb begin
    res_c  = '0;
    high_c = '0;
    br_c   = 1'b0;
    st_c   = '0;
    case (op)
      OP_ADD: begin
        res_c           = sum[W-1:0];
        st_c[ST_CARRY]  = sum[W];
        st_c[ST_OVF]    = mode && (I_dataA[W-1] == I_dataB[W-1]) && (sum[W-1] != I_dataA[W-1]);
      end
      OP_SUB: begin
        res_c           = diff[W-1:0];
        st_c[ST_CARRY]  = diff[W];
        st_c[ST_OVF]    = mode && (I_dataA[W-1] != I_dataB[W-1]) && (diff[W-1] != I_dataA[W-1]);
      end
      OP_OR:   res_c = I_dataA | I_dataB;
      OP_AND:  res_c = I_dataA & I_dataB;
      OP_XOR:  res_c = I_dataA ^ I_dataB;
      OP_NOT:  res_c = ~I_dataA;
      OP_DIV: begin
        res_c        = '1;
        high_c       = I_dataA;
        st_c[ST_DBZ] = 1'b1;
      end
      OP_LOAD: res_c = mode ? (W'(I_imm) << (W - IMMW)) : W'(I_imm);
      OP_CMP: begin
        res_c[CMP_EQ] = (I_dataA == I_dataB);
        res_c[CMP_AZ] = (I_dataA == '0);
        res_c[CMP_BZ] = (I_dataB == '0);
        res_c[CMP_GT] = mode ? ($signed(I_dataA) > $signed(I_dataB)) : (I_dataA > I_dataB);
        res_c[CMP_LT] = mode ? ($signed(I_dataA) < $signed(I_dataB)) : (I_dataA < I_dataB);
      end
      OP_SHL:  res_c = I_dataA << sh;
      OP_SHR:  res_c = mode ? $unsigned(sra) : (I_dataA >> sh);
      OP_JMPA: begin
        res_c = mode ? I_dataA : W'(I_imm);
        br_c  = 1'b1;
      end
      OP_JMPR: begin
        res_c = I_dataA;
        br_c  = I_dataB[{mode, I_imm[SW-2:0]}];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (iter_start) state_d = (op == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (iter_done || !iter_busy) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    high_d   = high_q;
    br_d     = br_q;
    st_d     = st_q;
    if (iter_done) begin
      valid_d  = 1'b1;
      result_d = iter_lo;
      high_d   = iter_hi;
      br_d     = 1'b0;
      st_d     = '0;
    end else if (accept && !iter_start) begin
      valid_d  = 1'b1;
      result_d = res_c;
      high_d   = high_c;
      br_d     = br_c;
      st_d     = st_c;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      high_q   <= '0;
      br_q     <= 1'b0;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      high_q   <= high_d;
      br_q     <= br_d;
      st_q     <= st_d;
    end
  end

  assign O_valid      = valid_q;
  assign O_dataResult = result_q;
  assign O_dataHigh   = high_q;
  assign O_shldBranch = br_q;
  assign O_status     = st_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench: table of vectors plus hand sequences for busy-ignore
// and reset-abort; results checked through a scoreboard queue.
module tb_alu_multicycle;

  localparam int W    = 16;
  localparam int IMMW = 8;

  logic            I_clk = 1'b0;
  logic            I_rst = 1'b1;
  logic            I_valid = 1'b0;
  logic            O_ready;
  logic [4:0]      I_aluop = '0;
  logic [W-1:0]    I_dataA = '0;
  logic [W-1:0]    I_dataB = '0;
  logic [IMMW-1:0] I_imm = '0;
  logic            O_valid;
  logic [W-1:0]    O_dataResult;
  logic [W-1:0]    O_dataHigh;
  logic            O_shldBranch;
  logic [2:0]      O_status;

  alu_multicycle #(.W(W), .IMMW(IMMW)) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_valid      (I_valid),
    .O_ready      (O_ready),
    .I_aluop      (I_aluop),
    .I_dataA      (I_dataA),
    .I_dataB      (I_dataB),
    .I_imm        (I_imm),
    .O_valid      (O_valid),
    .O_dataResult (O_dataResult),
    .O_dataHigh   (O_dataHigh),
    .O_shldBranch (O_shldBranch),
    .O_status     (O_status)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [4:0]  aluop;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic [15:0] res;
    logic [15:0] hi;
    logic        br;
    logic [2:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [4:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] imm,
                              logic [15:0] res, logic [15:0] hi, logic br, logic [2:0] st, int lat);
    vec_t v;
    v.aluop = op; v.a = a; v.b = b; v.imm = imm;
    v.res = res; v.hi = hi; v.br = br; v.st = st; v.lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge I_clk) begin
    if (O_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got O_valid=1 with result 0x%0h, expected no result", O_dataResult);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("op%b_result", e.aluop), 32'(O_dataResult), 32'(e.res));
        check($sformatf("op%b_high", e.aluop),   32'(O_dataHigh),   32'(e.hi));
        check($sformatf("op%b_branch", e.aluop), 32'(O_shldBranch), 32'(e.br));
        check($sformatf("op%b_status", e.aluop), 32'(O_status),     32'(e.st));
      end
    end
  end

  task automatic drive(input vec_t v);
    I_aluop = v.aluop;
    I_dataA = v.a;
    I_dataB = v.b;
    I_imm   = v.imm;
    I_valid = 1'b1;
    sb.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit inject);
    int low = 0;
    int lat = 0;
    @(negedge I_clk);
    for (int k = 0; k < 40 && !O_ready; k++) @(negedge I_clk);
    check($sformatf("v%0d_ready_before", idx), 32'(O_ready), 32'd1);
    drive(v);
    @(posedge I_clk);
    #1 I_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge I_clk);
      if (!O_ready) low++;
      if (inject && n == 3) begin
        I_valid = 1'b1;
        I_aluop = 5'b00000;
        I_dataA = 16'h1111;
        I_dataB = 16'h2222;
      end
      if (inject && n == 6) I_valid = 1'b0;
      if (O_valid) begin
        lat = n;
        break;
      end
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_ready_low_cycles", idx), 32'(low), 32'(v.lat - 1));
    #1;
    check($sformatf("v%0d_scoreboard_drained", idx), 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge I_clk);
    check($sformatf("v%0d_hold_result", idx), 32'(O_dataResult), 32'(v.res));
    check($sformatf("v%0d_valid_pulse", idx), 32'(O_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    vec_t m;

    vecs.push_back(mk(5'b00000, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b001, 1));
    vecs.push_back(mk(5'b00011, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 16'h0000, 1'b0, 3'b010, 1));
    vecs.push_back(mk(5'b00010, 16'h0001, 16'h0002, 8'h00, 16'hFFFF, 16'h0000, 1'b0, 3'b001, 1));
    vecs.push_back(mk(5'b00001, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 16'h0000, 1'b0, 3'b010, 1));
    vecs.push_back(mk(5'b00100, 16'h0FF0, 16'h00FF, 8'h00, 16'h0FFF, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b00110, 16'h0FF0, 16'h00FF, 8'h00, 16'h00F0, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b01000, 16'h0FF0, 16'h00FF, 8'h00, 16'h0F0F, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b01010, 16'h1234, 16'h0000, 8'h00, 16'hEDCB, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10001, 16'h0000, 16'h0000, 8'hA5, 16'hA500, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10000, 16'h0000, 16'h0000, 8'hA5, 16'h00A5, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10011, 16'h8000, 16'h0001, 8'h00, 16'h0010, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10010, 16'h8000, 16'h0001, 8'h00, 16'h0008, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10010, 16'h0000, 16'h0000, 8'h00, 16'h0007, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10100, 16'h0001, 16'h0013, 8'h00, 16'h0008, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10111, 16'h8000, 16'h0004, 8'h00, 16'hF800, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b10110, 16'h8000, 16'h0004, 8'h00, 16'h0800, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b11000, 16'h1234, 16'h0000, 8'h5A, 16'h005A, 16'h0000, 1'b1, 3'b000, 1));
    vecs.push_back(mk(5'b11001, 16'h1234, 16'h0000, 8'h5A, 16'h1234, 16'h0000, 1'b1, 3'b000, 1));
    vecs.push_back(mk(5'b11011, 16'hBEEF, 16'h0400, 8'h02, 16'hBEEF, 16'h0000, 1'b1, 3'b000, 1));
    vecs.push_back(mk(5'b11010, 16'hBEEF, 16'h0400, 8'h02, 16'hBEEF, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b11100, 16'h1234, 16'h5678, 8'hFF, 16'h0000, 16'h0000, 1'b0, 3'b000, 1));
    vecs.push_back(mk(5'b01101, 16'hFFFD, 16'h0007, 8'h00, 16'hFFEB, 16'hFFFF, 1'b0, 3'b000, 17));
    vecs.push_back(mk(5'b01100, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0001, 16'hFFFE, 1'b0, 3'b000, 17));
    vecs.push_back(mk(5'b01110, 16'd100,  16'd7,    8'h00, 16'h000E, 16'h0002, 1'b0, 3'b000, 17));
    vecs.push_back(mk(5'b01111, 16'hFFF9, 16'h0002, 8'h00, 16'hFFFD, 16'hFFFF, 1'b0, 3'b000, 17));
    vecs.push_back(mk(5'b01111, 16'h8000, 16'hFFFF, 8'h00, 16'h8000, 16'h0000, 1'b0, 3'b000, 17));
    vecs.push_back(mk(5'b01110, 16'h1234, 16'h0000, 8'h00, 16'hFFFF, 16'h1234, 1'b0, 3'b100, 1));

    repeat (3) @(negedge I_clk);
    I_rst = 1'b0;
    @(negedge I_clk);
    check("reset_valid",  32'(O_valid),      32'd0);
    check("reset_result", 32'(O_dataResult), 32'd0);
    check("reset_high",   32'(O_dataHigh),   32'd0);
    check("reset_branch", 32'(O_shldBranch), 32'd0);
    check("reset_status", 32'(O_status),     32'd0);
    check("reset_ready",  32'(O_ready),      32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i, 1'b0);

    // MUL with new requests and operand changes while busy.
    m = mk(5'b01101, 16'hFFFD, 16'h0007, 8'h00, 16'hFFEB, 16'hFFFF, 1'b0, 3'b000, 17);
    run_vec(m, 100, 1'b1);

    // Reset in cycle 5 of a MUL aborts it without a result.
    @(negedge I_clk);
    drive(mk(5'b01100, 16'h0123, 16'h0045, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 17));
    @(posedge I_clk);
    #1 I_valid = 1'b0;
    repeat (5) @(negedge I_clk);
    check("abort_busy_before_reset", 32'(O_ready), 32'd0);
    I_rst = 1'b1;
    sb.delete();
    @(negedge I_clk);
    check("abort_result", 32'(O_dataResult), 32'd0);
    check("abort_high",   32'(O_dataHigh),   32'd0);
    check("abort_status", 32'(O_status),     32'd0);
    check("abort_branch", 32'(O_shldBranch), 32'd0);
    I_rst = 1'b0;
    @(negedge I_clk);
    check("abort_ready_after_reset", 32'(O_ready), 32'd1);
    seen = 0;
    repeat (25) begin
      @(negedge I_clk);
      if (O_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    run_vec(mk(5'b00000, 16'h1000, 16'h0234, 8'h00, 16'h1234, 16'h0000, 1'b0, 3'b000, 1), 200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
